fu_ldst_cq: RTL and testbench
=============================

// Module: fu_ldst_cq
// PURPOSE
//  Parametrised load/store FU front/back end: registered AGU stage feeding the LSQ, plus a
//  DEPTH-entry completion queue (CQ) buffering LSQ load/store completions until the CDB
//  accepts them (stall_i). Branch-mask aware: squashes on mispredict, clears bits on correct.
//  Sits between the LS reservation station, the LSQ and the CDB arbiter.
// PARAMETERS
//  DATA_W     64  operand/address/result width
//  DISP_W     16  immediate displacement width, inst_i[DISP_W-1:0], sign-extended
//  PRF_IDX_W   6  physical register tag width
//  ROB_IDX_W   5  ROB index width (ports carry ROB_IDX_W+1 incl. wrap bit)
//  BR_MASK_W   4  branch mask width
//  CQ_DEPTH    4  completion queue entries, power of two, >=2
// PORTS
//  clk               in   1            clock
//  rst               in   1            synchronous reset, active-low
//  iss_vld_i         in   1            RS issues a load/store this cycle
//  iss_is_st_i       in   1            1=store, 0=load
//  opa_i             in   DATA_W       store data
//  opb_i             in   DATA_W       base address
//  inst_i            in   32           instruction (displacement field)
//  dest_tag_i        in   PRF_IDX_W    load destination tag
//  rob_idx_i         in   ROB_IDX_W+1  ROB index
//  br_mask_i         in   BR_MASK_W    branch mask of issued op
//  agu_rdy_o         out  1            AGU stage can accept issue
//  agu_vld_o         out  1            AGU register holds a valid op for LSQ
//  agu_addr_o        out  DATA_W       effective address
//  agu_st_data_o     out  DATA_W       store data
//  agu_is_st_o       out  1            op type
//  agu_dest_tag_o    out  PRF_IDX_W    tag
//  agu_rob_idx_o     out  ROB_IDX_W+1  ROB index
//  agu_br_mask_o     out  BR_MASK_W    current branch mask
//  lsq_agu_ack_i     in   1            LSQ consumes AGU op this cycle
//  lsq_done_vld_i    in   1            LSQ completion valid
//  lsq_done_is_st_i  in   1            completion is a store
//  lsq_data_i        in   DATA_W       load result
//  lsq_dest_tag_i    in   PRF_IDX_W    completion tag
//  lsq_rob_idx_i     in   ROB_IDX_W+1  completion ROB index
//  lsq_br_mask_i     in   BR_MASK_W    completion branch mask
//  cq_rdy_o          out  1            CQ accepts a completion (not full)
//  rob_br_recovery_i in   1            mispredict recovery this cycle
//  rob_br_pred_correct_i in 1          branch resolved correct this cycle
//  rob_br_tag_fix_i  in   BR_MASK_W    one-hot resolving branch tag
//  stall_i           in   1            CDB not accepting this cycle
//  cdb_vld_o / cdb_is_st_o / cdb_data_o / cdb_dest_tag_o / cdb_rob_idx_o / cdb_br_mask_o
//                    out  1/1/DATA_W/PRF_IDX_W/ROB_IDX_W+1/BR_MASK_W  CQ head to CDB
// BEHAVIOUR
//  - Reset (rst==0 at posedge): AGU valid, all CQ valids, head/tail/count cleared; all outputs 0
//    except agu_rdy_o=1, cq_rdy_o=1. Reset mid-operation discards all held ops.
//  - agu_rdy_o = ~agu_vld_o | lsq_agu_ack_i. Capture on iss_vld_i&agu_rdy_o:
//    addr = opb_i + sext(inst_i[DISP_W-1:0]) mod 2^DATA_W; visible next cycle. Held until ack.
//  - Kill rule (every held mask, AGU, CQ entries, and incoming issue/completion):
//    rob_br_recovery_i & |(mask & tag_fix) -> invalidate same edge; incoming op not captured.
//    rob_br_pred_correct_i -> mask &= ~tag_fix on all held and captured masks, same edge.
//  - CQ: circular, head/tail with extra wrap bit, count 0..CQ_DEPTH. Push on lsq_done_vld_i &
//    cq_rdy_o & not killed. cq_rdy_o = (count != CQ_DEPTH), registered count only: full with
//    simultaneous pop still reports not-ready. Push when not ready is a protocol error.
//  - Squashed entries stay as bubbles; head bubble is popped regardless of stall_i; count
//    includes bubbles. Head-to-CDB: cdb_vld_o = valid[head] & ~(killed this cycle); pop on
//    cdb_vld_o & ~stall_i. Order of completions preserved; min latency lsq->cdb 1 cycle.
//  - Stores: cdb_dest_tag_o forced 0, cdb_data_o 0, cdb_is_st_o=1.
// CONFIGURATION
//  FU_LDST_CQ_BYPASS_EN defined: when CQ empty (count==0) and ~stall_i, an unkilled incoming
//  completion drives cdb_* combinationally same cycle and is not enqueued (0-cycle latency).
//  Undefined: every completion is enqueued; min latency 1 cycle.
// STRUCTURE
//  Package ldst_pkg: cq_entry_t (vld,is_st,data,tag,rob_idx,br_mask), agu_op_t, width
//  localparams, function br_kill(mask,fix). Sub-module fu_ldst_agu: AGU register + kill/fix.
// TESTING
//  1 opb=0x1000, disp=0xFFF8 load -> agu_addr_o=0x0FF8 next cycle; ack -> agu_rdy_o=1.
//  2 stall_i=1, 4 completions -> cq_rdy_o=0 after 4th; release stall -> 4 pops in order, 1/cycle.
//  3 CQ masks 0001,0010,0001; recovery fix=0001 -> only entry 2 reaches CDB; bubbles pop.
//  4 pred_correct fix=0010 with AGU mask 0011 -> agu_br_mask_o=0001 next cycle, op retained.
//  5 rst=0 with full CQ and valid AGU -> next cycle cdb_vld_o=0, agu_vld_o=0, cq_rdy_o=1.
//  6 BYPASS_EN, empty CQ, completion tag 7 -> cdb_vld_o=1 same cycle; undefined -> next cycle.

Source files
------------

// File: rtl/ldst_pkg.sv
// Shared types and helpers for the load/store functional unit.
//
// Contents:
//   - default widths of the FU datapath (DATA_W, DISP_W, PRF_IDX_W, ROB_IDX_W,
//     BR_MASK_W, CQ_DEPTH); modules take these as parameter defaults
//   - cq_entry_t : one completion queue slot
//   - agu_op_t   : one address-generated op handed to the LSQ
//   - br_kill()  : does a branch mask depend on the resolving branch tag
//   - br_clear() : drop the resolving branch bit from a mask on a correct prediction
//
// The helpers and typedefs are sized by the localparams below. Modules that
// override BR_MASK_W must keep it equal to the value here.
package ldst_pkg;

  localparam int DATA_W    = 64;
  localparam int DISP_W    = 16;
  localparam int PRF_IDX_W = 6;
  localparam int ROB_IDX_W = 5;
  localparam int BR_MASK_W = 4;
  localparam int CQ_DEPTH  = 4;

  typedef logic [BR_MASK_W-1:0] br_mask_t;

  typedef struct packed {
    logic                 vld;
    logic                 is_st;
    logic [DATA_W-1:0]    data;
    logic [PRF_IDX_W-1:0] tag;
    logic [ROB_IDX_W:0]   rob_idx;
    br_mask_t             br_mask;
  } cq_entry_t;

  typedef struct packed {
    logic                 vld;
    logic                 is_st;
    logic [DATA_W-1:0]    addr;
    logic [DATA_W-1:0]    st_data;
    logic [PRF_IDX_W-1:0] tag;
    logic [ROB_IDX_W:0]   rob_idx;
    br_mask_t             br_mask;
  } agu_op_t;

  // True when the op carrying 'mask' sits in the shadow of branch 'fix'.
  function automatic logic br_kill(input br_mask_t mask, input br_mask_t fix);
    return |(mask & fix);
  endfunction

  // Mask after a same-cycle correct resolution of branch 'fix'.
  function automatic br_mask_t br_clear(input br_mask_t mask, input br_mask_t fix,
                                        input logic correct);
    return correct ? (mask & ~fix) : mask;
  endfunction

endpackage

// File: rtl/fu_ldst_agu.sv
// fu_ldst_agu: single-entry registered address generation stage.
//
// Computes addr = opb + sext(disp) for an issued load/store and holds the op
// until the LSQ acknowledges it. The held branch mask tracks branch resolution:
// a mispredict on a dependent branch drops the op, a correct prediction clears
// that branch bit.
//
// Handshake: an issue is taken on iss_vld_i & agu_rdy_o; the held op leaves on
// agu_vld_o & lsq_agu_ack_i. agu_rdy_o = ~agu_vld_o | lsq_agu_ack_i, so a new op
// can be captured in the same cycle the previous one is consumed.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   iss_*                     issue from the reservation station
//   disp_i                    displacement field (sign-extended here)
//   lsq_agu_ack_i             LSQ consumes the held op
//   rob_br_*                  branch resolution broadcast
//   agu_rdy_o, agu_*_o        stage status and held op
module fu_ldst_agu
  import ldst_pkg::*;
#(
  parameter int DATA_W    = ldst_pkg::DATA_W,
  parameter int DISP_W    = ldst_pkg::DISP_W,
  parameter int PRF_IDX_W = ldst_pkg::PRF_IDX_W,
  parameter int ROB_IDX_W = ldst_pkg::ROB_IDX_W,
  parameter int BR_MASK_W = ldst_pkg::BR_MASK_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_vld_i,
  input  logic                 iss_is_st_i,
  input  logic [DATA_W-1:0]    opa_i,
  input  logic [DATA_W-1:0]    opb_i,
  input  logic [DISP_W-1:0]    disp_i,
  input  logic [PRF_IDX_W-1:0] dest_tag_i,
  input  logic [ROB_IDX_W:0]   rob_idx_i,
  input  logic [BR_MASK_W-1:0] br_mask_i,
  input  logic                 lsq_agu_ack_i,
  input  logic                 rob_br_recovery_i,
  input  logic                 rob_br_pred_correct_i,
  input  logic [BR_MASK_W-1:0] rob_br_tag_fix_i,
  output logic                 agu_rdy_o,
  output logic                 agu_vld_o,
  output logic [DATA_W-1:0]    agu_addr_o,
  output logic [DATA_W-1:0]    agu_st_data_o,
  output logic                 agu_is_st_o,
  output logic [PRF_IDX_W-1:0] agu_dest_tag_o,
  output logic [ROB_IDX_W:0]   agu_rob_idx_o,
  output logic [BR_MASK_W-1:0] agu_br_mask_o
);

  logic                 vld_q;
  logic                 is_st_q;
  logic [DATA_W-1:0]    addr_q;
  logic [DATA_W-1:0]    st_data_q;
  logic [PRF_IDX_W-1:0] tag_q;
  logic [ROB_IDX_W:0]   rob_q;
  logic [BR_MASK_W-1:0] mask_q;

  logic                 rdy;
  logic                 in_kill;
  logic                 held_kill;
  logic [DATA_W-1:0]    disp_sext;

  assign rdy       = ~vld_q | lsq_agu_ack_i;
  assign in_kill   = rob_br_recovery_i & br_kill(br_mask_i, rob_br_tag_fix_i);
  assign held_kill = rob_br_recovery_i & br_kill(mask_q, rob_br_tag_fix_i);
  assign disp_sext = {{(DATA_W-DISP_W){disp_i[DISP_W-1]}}, disp_i};

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q     <= 1'b0;
      is_st_q   <= 1'b0;
      addr_q    <= '0;
      st_data_q <= '0;
      tag_q     <= '0;
      rob_q     <= '0;
      mask_q    <= '0;
    end else if (rdy) begin
      // Slot is free (or being freed): take the new op unless it is squashed.
      vld_q <= iss_vld_i & ~in_kill;
      if (iss_vld_i) begin
        is_st_q   <= iss_is_st_i;
        addr_q    <= opb_i + disp_sext;
        st_data_q <= opa_i;
        tag_q     <= dest_tag_i;
        rob_q     <= rob_idx_i;
        mask_q    <= br_clear(br_mask_i, rob_br_tag_fix_i, rob_br_pred_correct_i);
      end
    end else begin
      if (held_kill) vld_q <= 1'b0;
      mask_q <= br_clear(mask_q, rob_br_tag_fix_i, rob_br_pred_correct_i);
    end
  end

  assign agu_rdy_o      = rdy;
  assign agu_vld_o      = vld_q;
  assign agu_addr_o     = addr_q;
  assign agu_st_data_o  = st_data_q;
  assign agu_is_st_o    = is_st_q;
  assign agu_dest_tag_o = tag_q;
  assign agu_rob_idx_o  = rob_q;
  assign agu_br_mask_o  = mask_q;

endmodule

// File: rtl/fu_ldst_cq.sv
// fu_ldst_cq: load/store functional unit front and back end.
//
// Front: fu_ldst_agu computes effective addresses for ops issued by the LS
// reservation station and holds them for the LSQ.
// Back: a CQ_DEPTH-entry circular completion queue buffers LSQ completions until
// the CDB arbiter accepts them (stall_i low).
//
// Handshakes: issue taken on iss_vld_i & agu_rdy_o; AGU op consumed on
// agu_vld_o & lsq_agu_ack_i; completion taken on lsq_done_vld_i & cq_rdy_o;
// CQ head leaves on cdb_vld_o & ~stall_i. cq_rdy_o comes from the registered
// count only, so a full queue reports not-ready even while it pops.
//
// Branch handling: every held mask is checked against the resolving branch.
// Mispredicted dependents are dropped; in the CQ they become bubbles that keep
// their slot (and their place in count) and are popped at the head without
// waiting for the CDB. Correct predictions clear the branch bit.
//
// Configuration macro FU_LDST_CQ_BYPASS_EN: when defined, a completion arriving
// at an empty queue with the CDB free goes straight to cdb_* in the same cycle
// and is not enqueued. When undefined, every completion passes through the queue.
//
// Ports: clk, rst (sync, active-low); iss_* / opa_i / opb_i / inst_i / dest_tag_i /
// rob_idx_i / br_mask_i from the RS; agu_* to the LSQ with lsq_agu_ack_i back;
// lsq_done_* / lsq_data_i completions with cq_rdy_o back; rob_br_* branch
// resolution; stall_i and cdb_* towards the CDB arbiter.
module fu_ldst_cq
  import ldst_pkg::*;
#(
  parameter int DATA_W    = ldst_pkg::DATA_W,
  parameter int DISP_W    = ldst_pkg::DISP_W,
  parameter int PRF_IDX_W = ldst_pkg::PRF_IDX_W,
  parameter int ROB_IDX_W = ldst_pkg::ROB_IDX_W,
  parameter int BR_MASK_W = ldst_pkg::BR_MASK_W,
  parameter int CQ_DEPTH  = ldst_pkg::CQ_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_vld_i,
  input  logic                 iss_is_st_i,
  input  logic [DATA_W-1:0]    opa_i,
  input  logic [DATA_W-1:0]    opb_i,
  input  logic [31:0]          inst_i,
  input  logic [PRF_IDX_W-1:0] dest_tag_i,
  input  logic [ROB_IDX_W:0]   rob_idx_i,
  input  logic [BR_MASK_W-1:0] br_mask_i,
  output logic                 agu_rdy_o,
  output logic                 agu_vld_o,
  output logic [DATA_W-1:0]    agu_addr_o,
  output logic [DATA_W-1:0]    agu_st_data_o,
  output logic                 agu_is_st_o,
  output logic [PRF_IDX_W-1:0] agu_dest_tag_o,
  output logic [ROB_IDX_W:0]   agu_rob_idx_o,
  output logic [BR_MASK_W-1:0] agu_br_mask_o,
  input  logic                 lsq_agu_ack_i,
  input  logic                 lsq_done_vld_i,
  input  logic                 lsq_done_is_st_i,
  input  logic [DATA_W-1:0]    lsq_data_i,
  input  logic [PRF_IDX_W-1:0] lsq_dest_tag_i,
  input  logic [ROB_IDX_W:0]   lsq_rob_idx_i,
  input  logic [BR_MASK_W-1:0] lsq_br_mask_i,
  output logic                 cq_rdy_o,
  input  logic                 rob_br_recovery_i,
  input  logic                 rob_br_pred_correct_i,
  input  logic [BR_MASK_W-1:0] rob_br_tag_fix_i,
  input  logic                 stall_i,
  output logic                 cdb_vld_o,
  output logic                 cdb_is_st_o,
  output logic [DATA_W-1:0]    cdb_data_o,
  output logic [PRF_IDX_W-1:0] cdb_dest_tag_o,
  output logic [ROB_IDX_W:0]   cdb_rob_idx_o,
  output logic [BR_MASK_W-1:0] cdb_br_mask_o
);

  localparam int AW = $clog2(CQ_DEPTH);
  localparam logic [AW:0] CQ_FULL = (AW+1)'(CQ_DEPTH);

  // Bits of the instruction word outside the displacement are not needed here.
  logic unused_inst;
  assign unused_inst = ^inst_i[31:DISP_W];

  fu_ldst_agu #(
    .DATA_W   (DATA_W),
    .DISP_W   (DISP_W),
    .PRF_IDX_W(PRF_IDX_W),
    .ROB_IDX_W(ROB_IDX_W),
    .BR_MASK_W(BR_MASK_W)
  ) u_agu (
    .clk                  (clk),
    .rst                  (rst),
    .iss_vld_i            (iss_vld_i),
    .iss_is_st_i          (iss_is_st_i),
    .opa_i                (opa_i),
    .opb_i                (opb_i),
    .disp_i               (inst_i[DISP_W-1:0]),
    .dest_tag_i           (dest_tag_i),
    .rob_idx_i            (rob_idx_i),
    .br_mask_i            (br_mask_i),
    .lsq_agu_ack_i        (lsq_agu_ack_i),
    .rob_br_recovery_i    (rob_br_recovery_i),
    .rob_br_pred_correct_i(rob_br_pred_correct_i),
    .rob_br_tag_fix_i     (rob_br_tag_fix_i),
    .agu_rdy_o            (agu_rdy_o),
    .agu_vld_o            (agu_vld_o),
    .agu_addr_o           (agu_addr_o),
    .agu_st_data_o        (agu_st_data_o),
    .agu_is_st_o          (agu_is_st_o),
    .agu_dest_tag_o       (agu_dest_tag_o),
    .agu_rob_idx_o        (agu_rob_idx_o),
    .agu_br_mask_o        (agu_br_mask_o)
  );

  // ---------------------------------------------------------------------------
  // Completion queue storage
  // ---------------------------------------------------------------------------
  logic                 cq_vld  [CQ_DEPTH];
  logic                 cq_st   [CQ_DEPTH];
  logic [DATA_W-1:0]    cq_data [CQ_DEPTH];
  logic [PRF_IDX_W-1:0] cq_tag  [CQ_DEPTH];
  logic [ROB_IDX_W:0]   cq_rob  [CQ_DEPTH];
  logic [BR_MASK_W-1:0] cq_mask [CQ_DEPTH];

  // Pointers carry a wrap bit; count runs 0..CQ_DEPTH and includes bubbles.
  logic [AW:0] head_q;
  logic [AW:0] tail_q;
  logic [AW:0] count_q;

  logic [AW-1:0] head_idx;
  logic [AW-1:0] tail_idx;
  logic          rdy;
  logic          in_kill;
  logic          head_live;
  logic          byp;
  logic          push;
  logic          pop;

  assign head_idx = head_q[AW-1:0];
  assign tail_idx = tail_q[AW-1:0];
  assign rdy      = (count_q != CQ_FULL);
  assign in_kill  = rob_br_recovery_i & br_kill(lsq_br_mask_i, rob_br_tag_fix_i);

  // Head is presentable only if it is a real entry and not squashed right now.
  assign head_live = (count_q != '0) & cq_vld[head_idx] &
                     ~(rob_br_recovery_i & br_kill(cq_mask[head_idx], rob_br_tag_fix_i));

`ifdef FU_LDST_CQ_BYPASS_EN
  assign byp = (count_q == '0) & ~stall_i & lsq_done_vld_i & ~in_kill;
`else
  assign byp = 1'b0;
`endif

  assign push = lsq_done_vld_i & rdy & ~in_kill & ~byp;
  // A bubble (or an entry killed this cycle) leaves the head without the CDB.
  assign pop  = (count_q != '0) & (~head_live | ~stall_i);

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < CQ_DEPTH; i++) begin
        cq_vld[i]  <= 1'b0;
        cq_st[i]   <= 1'b0;
        cq_data[i] <= '0;
        cq_tag[i]  <= '0;
        cq_rob[i]  <= '0;
        cq_mask[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CQ_DEPTH; i++) begin
        if (rob_br_recovery_i & br_kill(cq_mask[i], rob_br_tag_fix_i)) cq_vld[i] <= 1'b0;
        cq_mask[i] <= br_clear(cq_mask[i], rob_br_tag_fix_i, rob_br_pred_correct_i);
      end
      // Push and pop never address the same slot: push needs count < DEPTH and
      // pop needs count > 0, so head == tail only when exactly one is possible.
      if (pop) begin
        cq_vld[head_idx] <= 1'b0;
        head_q           <= head_q + 1'b1;
      end
      if (push) begin
        cq_vld[tail_idx]  <= 1'b1;
        cq_st[tail_idx]   <= lsq_done_is_st_i;
        cq_data[tail_idx] <= lsq_data_i;
        cq_tag[tail_idx]  <= lsq_dest_tag_i;
        cq_rob[tail_idx]  <= lsq_rob_idx_i;
        cq_mask[tail_idx] <= br_clear(lsq_br_mask_i, rob_br_tag_fix_i, rob_br_pred_correct_i);
        tail_q            <= tail_q + 1'b1;
      end
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // CDB drive: head entry, or the bypassed completion. Stores carry no
  // destination or data, and all fields are zero when nothing is presented.
  // ---------------------------------------------------------------------------
  logic                 sel_vld;
  logic                 sel_st;
  logic [DATA_W-1:0]    sel_data;
  logic [PRF_IDX_W-1:0] sel_tag;
  logic [ROB_IDX_W:0]   sel_rob;
  logic [BR_MASK_W-1:0] sel_mask;

  always_comb begin
    sel_vld  = head_live;
    sel_st   = cq_st[head_idx];
    sel_data = cq_data[head_idx];
    sel_tag  = cq_tag[head_idx];
    sel_rob  = cq_rob[head_idx];
    sel_mask = cq_mask[head_idx];
    if (byp) begin
      sel_vld  = 1'b1;
      sel_st   = lsq_done_is_st_i;
      sel_data = lsq_data_i;
      sel_tag  = lsq_dest_tag_i;
      sel_rob  = lsq_rob_idx_i;
      sel_mask = lsq_br_mask_i;
    end
  end

  assign cq_rdy_o       = rdy;
  assign cdb_vld_o      = sel_vld;
  assign cdb_is_st_o    = sel_vld & sel_st;
  assign cdb_data_o     = (sel_vld & ~sel_st) ? sel_data : '0;
  assign cdb_dest_tag_o = (sel_vld & ~sel_st) ? sel_tag : '0;
  assign cdb_rob_idx_o  = sel_vld ? sel_rob : '0;
  assign cdb_br_mask_o  = sel_vld ? sel_mask : '0;

endmodule

// File: tb/tb_fu_ldst_cq.sv
// Directed testbench for fu_ldst_cq with a CDB scoreboard.
module tb_fu_ldst_cq;

  localparam int W = 1 + 6 + 6 + 64;  // {is_st, tag, rob, data}

  logic        clk;
  logic        rst;
  logic        iss_vld_i, iss_is_st_i;
  logic [63:0] opa_i, opb_i;
  logic [31:0] inst_i;
  logic [5:0]  dest_tag_i, rob_idx_i;
  logic [3:0]  br_mask_i;
  logic        agu_rdy_o, agu_vld_o, agu_is_st_o;
  logic [63:0] agu_addr_o, agu_st_data_o;
  logic [5:0]  agu_dest_tag_o, agu_rob_idx_o;
  logic [3:0]  agu_br_mask_o;
  logic        lsq_agu_ack_i, lsq_done_vld_i, lsq_done_is_st_i;
  logic [63:0] lsq_data_i;
  logic [5:0]  lsq_dest_tag_i, lsq_rob_idx_i;
  logic [3:0]  lsq_br_mask_i;
  logic        cq_rdy_o;
  logic        rob_br_recovery_i, rob_br_pred_correct_i;
  logic [3:0]  rob_br_tag_fix_i;
  logic        stall_i;
  logic        cdb_vld_o, cdb_is_st_o;
  logic [63:0] cdb_data_o;
  logic [5:0]  cdb_dest_tag_o, cdb_rob_idx_o;
  logic [3:0]  cdb_br_mask_o;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  fu_ldst_cq dut (
    .clk(clk), .rst(rst),
    .iss_vld_i(iss_vld_i), .iss_is_st_i(iss_is_st_i), .opa_i(opa_i), .opb_i(opb_i),
    .inst_i(inst_i), .dest_tag_i(dest_tag_i), .rob_idx_i(rob_idx_i), .br_mask_i(br_mask_i),
    .agu_rdy_o(agu_rdy_o), .agu_vld_o(agu_vld_o), .agu_addr_o(agu_addr_o),
    .agu_st_data_o(agu_st_data_o), .agu_is_st_o(agu_is_st_o),
    .agu_dest_tag_o(agu_dest_tag_o), .agu_rob_idx_o(agu_rob_idx_o),
    .agu_br_mask_o(agu_br_mask_o), .lsq_agu_ack_i(lsq_agu_ack_i),
    .lsq_done_vld_i(lsq_done_vld_i), .lsq_done_is_st_i(lsq_done_is_st_i),
    .lsq_data_i(lsq_data_i), .lsq_dest_tag_i(lsq_dest_tag_i),
    .lsq_rob_idx_i(lsq_rob_idx_i), .lsq_br_mask_i(lsq_br_mask_i), .cq_rdy_o(cq_rdy_o),
    .rob_br_recovery_i(rob_br_recovery_i), .rob_br_pred_correct_i(rob_br_pred_correct_i),
    .rob_br_tag_fix_i(rob_br_tag_fix_i), .stall_i(stall_i),
    .cdb_vld_o(cdb_vld_o), .cdb_is_st_o(cdb_is_st_o), .cdb_data_o(cdb_data_o),
    .cdb_dest_tag_o(cdb_dest_tag_o), .cdb_rob_idx_o(cdb_rob_idx_o),
    .cdb_br_mask_o(cdb_br_mask_o)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- helpers
  function automatic logic [W-1:0] pk(input logic st, input logic [5:0] tag,
                                      input logic [5:0] rob, input logic [63:0] data);
    return {st, tag, rob, data};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic issue(input logic st, input logic [63:0] a, input logic [63:0] b,
                       input logic [31:0] inst, input logic [5:0] tag,
                       input logic [5:0] rob, input logic [3:0] mask);
    iss_vld_i = 1'b1; iss_is_st_i = st; opa_i = a; opb_i = b; inst_i = inst;
    dest_tag_i = tag; rob_idx_i = rob; br_mask_i = mask;
  endtask

  // Drives one completion; when 'expect_out' is set its CDB image is queued.
  task automatic complete(input logic st, input logic [63:0] data, input logic [5:0] tag,
                          input logic [5:0] rob, input logic [3:0] mask,
                          input logic expect_out);
    lsq_done_vld_i = 1'b1; lsq_done_is_st_i = st; lsq_data_i = data;
    lsq_dest_tag_i = tag; lsq_rob_idx_i = rob; lsq_br_mask_i = mask;
    if (expect_out) exp_q.push_back(st ? pk(1'b1, 6'd0, rob, 64'd0) : pk(1'b0, tag, rob, data));
  endtask

  // ---------------------------------------------------------------- scoreboard
  // A head shown while the CDB is free leaves at the next edge: match it here.
  always @(negedge clk) begin
    if (rst && cdb_vld_o && !stall_i) begin
      total++;
      assert (exp_q.size() != 0)
      else begin
        bad++;
        $error("FAIL cdb_unexpected observed=tag%0h expected=no_output", cdb_dest_tag_o);
      end
      if (exp_q.size() != 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("cdb_payload", 128'(pk(cdb_is_st_o, cdb_dest_tag_o, cdb_rob_idx_o, cdb_data_o)),
            128'(e));
      end
    end
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    logic [63:0] d;
    rst = 1'b0;
    iss_vld_i = 0; iss_is_st_i = 0; opa_i = 0; opb_i = 0; inst_i = 0;
    dest_tag_i = 0; rob_idx_i = 0; br_mask_i = 0; lsq_agu_ack_i = 0;
    lsq_done_vld_i = 0; lsq_done_is_st_i = 0; lsq_data_i = 0; lsq_dest_tag_i = 0;
    lsq_rob_idx_i = 0; lsq_br_mask_i = 0; rob_br_recovery_i = 0;
    rob_br_pred_correct_i = 0; rob_br_tag_fix_i = 0; stall_i = 0;
    repeat (3) tick();
    chk("rst_agu_rdy", 128'(agu_rdy_o), 128'(1));
    chk("rst_agu_vld", 128'(agu_vld_o), 128'(0));
    chk("rst_cq_rdy",  128'(cq_rdy_o),  128'(1));
    chk("rst_cdb_vld", 128'(cdb_vld_o), 128'(0));
    rst = 1'b1;
    tick();

    // 1: load address with negative displacement.
    issue(1'b0, 64'h0, 64'h1000, 32'h0000_FFF8, 6'd3, 6'd1, 4'b0000);
    tick();
    iss_vld_i = 1'b0;
    chk("agu_vld",  128'(agu_vld_o),      128'(1));
    chk("agu_addr", 128'(agu_addr_o),     128'(64'h0FF8));
    chk("agu_tag",  128'(agu_dest_tag_o), 128'(3));
    chk("agu_busy", 128'(agu_rdy_o),      128'(0));
    lsq_agu_ack_i = 1'b1;
    #1;
    chk("agu_rdy_on_ack", 128'(agu_rdy_o), 128'(1));
    tick();
    lsq_agu_ack_i = 1'b0;
    chk("agu_drained", 128'(agu_vld_o), 128'(0));

    // 2: fill under stall, then drain in order one per cycle.
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom};
      complete(1'(i == 2), d, 6'(10 + i), 6'(i), 4'b0000, 1'b1);
      tick();
    end
    lsq_done_vld_i = 1'b0;
    chk("cq_full_rdy",   128'(cq_rdy_o),  128'(0));
    chk("cq_head_shown", 128'(cdb_vld_o), 128'(1));
    stall_i = 1'b0;
    tick();
    chk("cq_rdy_after_pop", 128'(cq_rdy_o), 128'(1));
    repeat (3) tick();
    chk("cq_drained_vld", 128'(cdb_vld_o),    128'(0));
    chk("cq_drained_q",   128'(exp_q.size()), 128'(0));

    // 3: recovery squashes entries 0 and 2; only entry 1 reaches the CDB.
    stall_i = 1'b1;
    complete(1'b0, 64'hA0, 6'd20, 6'd4, 4'b0001, 1'b0); tick();
    complete(1'b0, 64'hA1, 6'd21, 6'd5, 4'b0010, 1'b1); tick();
    complete(1'b0, 64'hA2, 6'd22, 6'd6, 4'b0001, 1'b0); tick();
    lsq_done_vld_i = 1'b0;
    rob_br_recovery_i = 1'b1; rob_br_tag_fix_i = 4'b0001;
    #1;
    chk("kill_head_hidden", 128'(cdb_vld_o), 128'(0));
    tick();
    rob_br_recovery_i = 1'b0; rob_br_tag_fix_i = 4'b0000;
    chk("survivor_vld", 128'(cdb_vld_o),      128'(1));
    chk("survivor_tag", 128'(cdb_dest_tag_o), 128'(21));
    stall_i = 1'b0;
    repeat (3) tick();
    chk("kill_drained_vld", 128'(cdb_vld_o),    128'(0));
    chk("kill_drained_rdy", 128'(cq_rdy_o),     128'(1));
    chk("kill_drained_q",   128'(exp_q.size()), 128'(0));

    // 4: correct prediction clears one mask bit, op kept.
    issue(1'b1, 64'hDEAD_BEEF, 64'h2000, 32'h0000_0010, 6'd9, 6'd7, 4'b0011);
    tick();
    iss_vld_i = 1'b0;
    chk("st_mask_in",  128'(agu_br_mask_o), 128'(4'b0011));
    chk("st_addr",     128'(agu_addr_o),    128'(64'h2010));
    chk("st_data",     128'(agu_st_data_o), 128'(64'hDEAD_BEEF));
    rob_br_pred_correct_i = 1'b1; rob_br_tag_fix_i = 4'b0010;
    tick();
    rob_br_pred_correct_i = 1'b0; rob_br_tag_fix_i = 4'b0000;
    chk("fix_mask", 128'(agu_br_mask_o), 128'(4'b0001));
    chk("fix_kept", 128'(agu_vld_o),     128'(1));
    lsq_agu_ack_i = 1'b1;
    tick();
    lsq_agu_ack_i = 1'b0;

    // 5: reset with a full CQ and a held AGU op.
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      complete(1'b0, 64'(i), 6'(30 + i), 6'(i), 4'b0000, 1'b0);
      tick();
    end
    lsq_done_vld_i = 1'b0;
    issue(1'b0, 64'h0, 64'h3000, 32'h0, 6'd1, 6'd1, 4'b0000);
    tick();
    iss_vld_i = 1'b0;
    chk("pre_rst_cq_rdy",  128'(cq_rdy_o),  128'(0));
    chk("pre_rst_agu_vld", 128'(agu_vld_o), 128'(1));
    rst = 1'b0;
    tick();
    chk("mid_rst_cdb_vld", 128'(cdb_vld_o), 128'(0));
    chk("mid_rst_agu_vld", 128'(agu_vld_o), 128'(0));
    chk("mid_rst_cq_rdy",  128'(cq_rdy_o),  128'(1));
    chk("mid_rst_agu_rdy", 128'(agu_rdy_o), 128'(1));
    rst = 1'b1;
    stall_i = 1'b0;
    tick();
    chk("post_rst_cdb_vld", 128'(cdb_vld_o), 128'(0));

    // 6: completion into an empty CQ with the CDB free.
    complete(1'b0, 64'h77, 6'd7, 6'd2, 4'b0000, 1'b1);
    #1;
`ifdef FU_LDST_CQ_BYPASS_EN
    chk("lat_same_cycle", 128'(cdb_vld_o), 128'(1));
`else
    chk("lat_same_cycle", 128'(cdb_vld_o), 128'(0));
`endif
    tick();
    lsq_done_vld_i = 1'b0;
    #1;
`ifdef FU_LDST_CQ_BYPASS_EN
    chk("lat_next_cycle", 128'(cdb_vld_o), 128'(0));
`else
    chk("lat_next_cycle", 128'(cdb_vld_o),      128'(1));
    chk("lat_next_tag",   128'(cdb_dest_tag_o), 128'(7));
`endif
    repeat (2) tick();
    chk("final_q_empty", 128'(exp_q.size()), 128'(0));
    chk("final_cdb_idle", 128'(cdb_vld_o), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
